imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. A byte stream with valid/ready
// handshake carries a 16-bit little-endian word count N, then N instruction
// words, each sent as four bytes little-endian. The bytes are packed into a
// DEPTH x XLEN memory. The core is held in reset until the whole image has
// been written. The core fetches from this memory through a combinational
// read port.
//
// Ports
//   clk_i         clock; all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   rx_valid_i    byte-stream valid
//   rx_data_i     byte-stream data
//   rx_ready_o    loader accepts a byte this cycle
//   instr_addr_i  byte address from the core program counter
//   instr_data_o  instruction word returned to the core (zero latency)
//   cpu_rst_o     reset to the core, held until the image is loaded
//   load_done_o   program image loaded
//   err_o         illegal image length received (0 or larger than DEPTH)
//
// States
//   LEN_LO | waiting for the low byte of the word count
//   LEN_HI | waiting for the high byte of the word count
//   DATA   | assembling and writing instruction words
//   DONE   | image loaded, core released (terminal)
//   ERR    | illegal length, core held in reset (terminal)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_valid_i,
    input  logic [7:0]      rx_data_i,
    output logic            rx_ready_o,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic [XLEN-1:0] instr_data_o,
    output logic            cpu_rst_o,
    output logic            load_done_o,
    output logic            err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t          state_q;
    logic [15:0]     len_q;
    logic [AW-1:0]   idx_q;
    logic [1:0]      lane_q;
    logic [XLEN-1:0] word_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic            ready_st;
    logic            accept;
    logic [XLEN-1:0] word_d;
    logic [15:0]     len_d;
    logic            len_bad;
    logic            last_word;
    logic            wr_en;
    logic            in_range;

    assign ready_st = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign accept   = rx_valid_i && ready_st;

    // Partial word with the incoming byte merged into its lane; on lane 3
    // this is the complete word that goes to memory.
    always_comb begin
        word_d = word_q;
        word_d[8*lane_q +: 8] = rx_data_i;
    end

    assign len_d     = {rx_data_i, len_q[7:0]};
    assign len_bad   = (len_d == 16'd0) || (17'(len_d) > 17'(DEPTH));
    assign last_word = (16'(idx_q) == (len_q - 16'd1));
    assign wr_en     = !rst_i && accept && (state_q == DATA) && (lane_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LEN_LO;
            len_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
        end else begin
            case (state_q)
                LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data_i;
                        state_q    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data_i;
                        if (len_bad) begin
                            state_q <= ERR;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                            lane_q  <= '0;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        word_q <= word_d;
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            // Wraps to 0 when N == DEPTH; harmless since the FSM stops.
                            idx_q <= idx_q + AW'(1);
                            if (last_word) begin
                                state_q <= DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is never reset: a reload only overwrites the words it carries.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[idx_q] <= word_d;
        end
    end

    // Asynchronous read: a same-cycle write to the fetched word shows the
    // old content until the edge.
    assign in_range     = ((instr_addr_i >> (AW + 2)) == '0);
    assign instr_data_o = in_range ? mem[instr_addr_i[AW+1:2]] : NOP;

    // While rst_i is high the outputs already show the post-reset LEN_LO
    // values, whatever the current state.
    assign rx_ready_o  = rst_i || ready_st;
    assign cpu_rst_o   = rst_i || (state_q != DONE);
    assign load_done_o = !rst_i && (state_q == DONE);
    assign err_o       = !rst_i && (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int XLEN  = 32;
    localparam int DEPTH = 256;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            rx_valid_i;
    logic [7:0]      rx_data_i;
    logic            rx_ready_o;
    logic [XLEN-1:0] instr_addr_i;
    logic [XLEN-1:0] instr_data_o;
    logic            cpu_rst_o;
    logic            load_done_o;
    logic            err_o;

    imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .instr_addr_i (instr_addr_i),
        .instr_data_o (instr_data_o),
        .cpu_rst_o    (cpu_rst_o),
        .load_done_o  (load_done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_mem [DEPTH];
    int          n_pass  = 0;
    int          n_total = 0;

    // Stimulus helpers: inputs change 1 time unit after the rising edge,
    // outputs are sampled there too.
    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid_i = 1'b0;
            rx_data_i  = 8'($urandom);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int l = 0; l < 4; l++) begin
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
            send_byte(w[8*l +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; instr_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_total++;
        if ({rx_ready_o, cpu_rst_o, load_done_o, err_o} !== 4'b1100)
            $display("FAIL reset_outputs: got ready/cpu_rst/done/err=%b expected 1100",
                     {rx_ready_o, cpu_rst_o, load_done_o, err_o});
        else n_pass++;
    endtask

    task automatic test_normal();
        logic [31:0] w [2];
        w[0] = 32'h0050_0093;
        w[1] = 32'h00A0_0113;
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{addr: 32'(i * 4), data: w[i]});
            exp_mem[i] = w[i];
        end
        send_word(w[0], 0);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'hA0);
        n_total++;
        if (load_done_o !== 1'b0 || cpu_rst_o !== 1'b1)
            $display("FAIL normal_early_done: got done=%b cpu_rst=%b expected done=0 cpu_rst=1",
                     load_done_o, cpu_rst_o);
        else n_pass++;
        send_byte(8'h00);
        n_total++;
        if ({load_done_o, cpu_rst_o, rx_ready_o, err_o} !== 4'b1000)
            $display("FAIL normal_done: got done/cpu_rst/ready/err=%b expected 1000",
                     {load_done_o, cpu_rst_o, rx_ready_o, err_o});
        else n_pass++;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            instr_addr_i = e.addr;
            #1;
            n_total++;
            if (instr_data_o !== e.data)
                $display("FAIL normal_read addr=%h: got %h expected %h", e.addr, instr_data_o, e.data);
            else n_pass++;
        end
        // rst_i asserted while in DONE: outputs already show reset values.
        rst_i = 1'b1;
        #1;
        n_total++;
        if ({rx_ready_o, cpu_rst_o, load_done_o, err_o} !== 4'b1100)
            $display("FAIL reset_in_done: got ready/cpu_rst/done/err=%b expected 1100",
                     {rx_ready_o, cpu_rst_o, load_done_o, err_o});
        else n_pass++;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_zero_len();
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        for (int c = 0; c < 21; c++) begin
            n_total++;
            if ({err_o, rx_ready_o, cpu_rst_o, load_done_o} !== 4'b1010)
                $display("FAIL zero_len cycle %0d: got err/ready/cpu_rst/done=%b expected 1010",
                         c, {err_o, rx_ready_o, cpu_rst_o, load_done_o});
            else n_pass++;
            rx_valid_i = 1'b1;
            rx_data_i  = 8'($urandom);
            @(posedge clk_i);
            #1;
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic test_over_len();
        logic [31:0] w;
        do_reset();
        send_byte(8'h01); send_byte(8'h01);
        n_total++;
        if ({err_o, rx_ready_o, cpu_rst_o} !== 3'b101)
            $display("FAIL over_len_257: got err/ready/cpu_rst=%b expected 101",
                     {err_o, rx_ready_o, cpu_rst_o});
        else n_pass++;

        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            sb.push_back('{addr: 32'(i * 4), data: w});
            exp_mem[i] = w;
            if (i == DEPTH - 1) begin
                send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]);
                n_total++;
                if (load_done_o !== 1'b0)
                    $display("FAIL full_early_done: got done=%b expected 0", load_done_o);
                else n_pass++;
                send_byte(w[31:24]);
            end else begin
                send_word(w, 0);
            end
        end
        n_total++;
        if ({load_done_o, cpu_rst_o, err_o} !== 3'b100)
            $display("FAIL full_done: got done/cpu_rst/err=%b expected 100",
                     {load_done_o, cpu_rst_o, err_o});
        else n_pass++;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            instr_addr_i = e.addr;
            #1;
            n_total++;
            if (instr_data_o !== e.data)
                $display("FAIL full_read addr=%h: got %h expected %h", e.addr, instr_data_o, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_gapped();
        logic [31:0] w;
        do_reset();
        idle(3);
        send_byte(8'h03);
        idle(2);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            sb.push_back('{addr: 32'(i * 4), data: w});
            exp_mem[i] = w;
            if (i == 1) begin
                // Long stall mid-word: lane and partial word must hold.
                send_byte(w[7:0]); send_byte(w[15:8]);
                idle(40);
                send_byte(w[23:16]); send_byte(w[31:24]);
            end else begin
                send_word(w, 3);
            end
        end
        n_total++;
        if (load_done_o !== 1'b1)
            $display("FAIL gapped_done: got done=%b expected 1", load_done_o);
        else n_pass++;
        // Word 3 belongs to the previous image and must be untouched.
        sb.push_back('{addr: 32'd12, data: exp_mem[3]});
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            instr_addr_i = e.addr;
            #1;
            n_total++;
            if (instr_data_o !== e.data)
                $display("FAIL gapped_read addr=%h: got %h expected %h", e.addr, instr_data_o, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        instr_addr_i = 32'h0;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h44;
        #1;
        n_total++;
        if (instr_data_o !== exp_mem[0])
            $display("FAIL read_during_write: got %h expected old %h", instr_data_o, exp_mem[0]);
        else n_pass++;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        exp_mem[0] = 32'h4433_2211;
        n_total++;
        if (instr_data_o !== exp_mem[0])
            $display("FAIL write_word0: got %h expected %h", instr_data_o, exp_mem[0]);
        else n_pass++;
        send_byte(8'h55); send_byte(8'h66);
        // Byte presented during the reset cycle must be discarded.
        rst_i      = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hAA;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        rx_valid_i = 1'b0;
        n_total++;
        if ({rx_ready_o, cpu_rst_o, load_done_o, err_o} !== 4'b1100)
            $display("FAIL reset_mid_outputs: got ready/cpu_rst/done/err=%b expected 1100",
                     {rx_ready_o, cpu_rst_o, load_done_o, err_o});
        else n_pass++;
        send_byte(8'h01); send_byte(8'h00);
        exp_mem[0] = 32'hDEAD_BEEF;
        sb.push_back('{addr: 32'h0, data: exp_mem[0]});
        send_word(32'hDEAD_BEEF, 0);
        n_total++;
        if ({load_done_o, err_o, cpu_rst_o} !== 3'b100)
            $display("FAIL reload_done: got done/err/cpu_rst=%b expected 100",
                     {load_done_o, err_o, cpu_rst_o});
        else n_pass++;
        sb.push_back('{addr: 32'h4, data: exp_mem[1]});
        sb.push_back('{addr: 32'h3, data: exp_mem[0]});
        sb.push_back('{addr: 32'h3FF, data: exp_mem[255]});
        sb.push_back('{addr: 32'h400, data: 32'h0000_0013});
        sb.push_back('{addr: 32'hFFFF_FFFC, data: 32'h0000_0013});
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            instr_addr_i = e.addr;
            #1;
            n_total++;
            if (instr_data_o !== e.data)
                $display("FAIL reload_read addr=%h: got %h expected %h", e.addr, instr_data_o, e.data);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_len();
        test_over_len();
        test_gapped();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
